// File: rtl/edge_event_arbiter.sv
// Round-robin scheduler for rising-edge events on N request lines (both edges with EDGE_BOTH_EN).
// Latency: edge sampled at posedge k -> ev_valid after posedge k+1; one idle bubble between grants.
// Backpressure: offer held (ev_id stable) until ev_ready; repeat edges while pending merge and set ovf.
module edge_event_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    x,
  input  logic            ev_ready,
  output logic            ev_valid,
  output logic [ID_W-1:0] ev_id,
  input  logic            ovf_clr,
  output logic [N-1:0]    ovf
);

  localparam logic [0:0]      S_IDLE  = 1'b0;
  localparam logic [0:0]      S_OFFER = 1'b1;
  localparam logic [ID_W:0]   L_N     = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] L_LAST  = ID_W'(N-1);

  logic [N-1:0]    r_x_prev;
  logic [N-1:0]    r_pending;
  logic [N-1:0]    r_ovf;
  logic [0:0]      r_state;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_rr_ptr;

  logic [N-1:0]    w_edge;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_ovf_set;
  logic            w_hs;
  logic            w_pick_vld;
  logic [ID_W-1:0] w_pick_id;
  logic [ID_W-1:0] w_idx;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_next_ptr;

`ifdef EDGE_BOTH_EN
  assign w_edge = x ^ r_x_prev;
`else
  assign w_edge = x & ~r_x_prev;
`endif

  // Handshake completes on the clock edge where an offer meets ev_ready.
  assign w_hs       = (r_state == S_OFFER) && ev_ready;
  assign w_clr      = w_hs ? (N'(1) << r_id) : '0;
  // A repeat edge only overflows if the pending bit is not being consumed this cycle.
  assign w_ovf_set  = w_edge & r_pending & ~w_clr;
  assign w_next_ptr = (r_id == L_LAST) ? '0 : r_id + ID_W'(1);

  assign ev_valid = (r_state == S_OFFER);
  assign ev_id    = r_id;
  assign ovf      = r_ovf;

  // Round-robin search from r_rr_ptr; iterating downwards lets the nearest set bit win.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= L_N) begin
        w_sum = w_sum - L_N;
      end
      w_idx = w_sum[ID_W-1:0];
      if (r_pending[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = w_idx;
      end
    end
  end

  // Input history; all-ones so lines already high at reset release raise no event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x_prev <= '1;
    end else begin
      r_x_prev <= x;
    end
  end

  // Pending events: a new edge wins over the grant clearing the same channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  // Sticky overflow flags; a fresh overflow survives a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
    end
  end

  // Grant FSM: latch a winner in IDLE, hold the offer until accepted, then advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_id    <= w_pick_id;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ev_ready) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a cycle-level reference model.
// Model tracks pending events as a set, offers and round-robin order with plain integer arithmetic.
// Covers both builds; define EDGE_BOTH_EN for the bench as for the design.
module tb_edge_event_arbiter;

  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic            clk;
  logic            reset;
  logic [N-1:0]    x;
  logic            ev_ready;
  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic            ovf_clr;
  logic [N-1:0]    ovf;

  int n_checks = 0;
  int n_errors = 0;
  int glog[$];

  // Reference model state
  bit [N-1:0] m_prev;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;
  bit         m_off;
  int         m_id;
  int         m_ptr;

  edge_event_arbiter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '1;
    m_pend = '0;
    m_ovf  = '0;
    m_off  = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
  endtask

  // One clock of the reference behaviour, using the inputs that the next posedge will sample.
  task automatic model_step();
    bit [N-1:0] e;
    bit [N-1:0] set_ovf;
    bit         hs;
    int         j;
    for (int i = 0; i < N; i++) begin
`ifdef EDGE_BOTH_EN
      e[i] = (x[i] != m_prev[i]);
`else
      e[i] = x[i] && !m_prev[i];
`endif
    end
    hs = m_off && ev_ready;
    for (int i = 0; i < N; i++) begin
      set_ovf[i] = e[i] && m_pend[i] && !(hs && (m_id == i));
    end
    m_ovf = ovf_clr ? set_ovf : (m_ovf | set_ovf);
    if (m_off) begin
      if (hs) begin
        m_pend[m_id] = 1'b0;
        m_ptr        = (m_id + 1) % N;
        m_off        = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_pend[j]) begin
          m_id  = j;
          m_off = 1'b1;
          break;
        end
      end
    end
    m_pend = m_pend | e;
    m_prev = x;
  endtask

  // Advance one cycle, log accepted grants, compare every output with the model.
  task automatic tick();
    if (ev_valid && ev_ready) glog.push_back(int'(ev_id));
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 32'(ev_valid), 32'(m_off));
    chk("id",    32'(ev_id),    32'(m_id));
    chk("ovf",   32'(ovf),      32'(m_ovf));
  endtask

  task automatic do_reset(input logic [N-1:0] xv);
    reset    = 1'b0;
    x        = xv;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(ev_valid), 32'd0);
      chk("rst_id",    32'(ev_id),    32'd0);
      chk("rst_ovf",   32'(ovf),      32'd0);
    end
    reset = 1'b1;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    repeat (16) tick();
    glog.delete();
  endtask

  initial begin
    // 1: inputs high through reset release give no events
    do_reset(4'b1111);
    repeat (10) tick();

    // 2: single rising edge latency and one grant
    do_reset(4'b0000);
    drain();
    x = 4'b0100;
    tick();
    chk("t2_lat0", 32'(ev_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(ev_valid), 32'd1);
    chk("t2_id",    32'(ev_id),    32'd2);
    tick();
    chk("t2_bubble", 32'(ev_valid), 32'd0);
    repeat (4) tick();
    chk("t2_ngrant", 32'(glog.size()), 32'd1);

    // 3: simultaneous edges granted in round-robin order
    do_reset(4'b0000);
    drain();
    x = 4'b1011;
    repeat (10) tick();
    chk("t3_n", 32'(glog.size()), 32'd3);
    chk("t3_g0", 32'(glog[0]), 32'd0);
    chk("t3_g1", 32'(glog[1]), 32'd1);
    chk("t3_g2", 32'(glog[2]), 32'd3);
    x = 4'b0000;
    drain();
    x = 4'b1001;
    repeat (8) tick();
    chk("t3b_n", 32'(glog.size()), 32'd2);
    chk("t3b_g0", 32'(glog[0]), 32'd0);
    chk("t3b_g1", 32'(glog[1]), 32'd3);

    // 4: backpressure, merged repeat edge, overflow and its clear
    do_reset(4'b0000);
    drain();
    ev_ready = 1'b0;
    x = 4'b0010;
    tick();
    tick();
    x = 4'b0000;
    tick();
    tick();
    x = 4'b0010;
    repeat (4) tick();
    chk("t4_valid", 32'(ev_valid), 32'd1);
    chk("t4_id",    32'(ev_id),    32'd1);
    chk("t4_ovf",   32'(ovf),      32'b0010);
    ev_ready = 1'b1;
    repeat (6) tick();
    chk("t4_ngrant", 32'(glog.size()), 32'd1);
    chk("t4_gid",    32'(glog[0]),     32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovfclr", 32'(ovf), 32'd0);

    // 5: edge coinciding with its own handshake re-arms without overflow
    do_reset(4'b0000);
    drain();
    ev_ready = 1'b0;
    x = 4'b0100;
    tick();
    tick();
`ifdef EDGE_BOTH_EN
    x = 4'b0000;
    ev_ready = 1'b1;
    tick();
`else
    x = 4'b0000;
    tick();
    x = 4'b0100;
    ev_ready = 1'b1;
    tick();
`endif
    ev_ready = 1'b0;
    chk("t5_bubble", 32'(ev_valid), 32'd0);
    chk("t5_ovf",    32'(ovf),      32'd0);
    tick();
    chk("t5_reoffer", 32'(ev_valid), 32'd1);
    chk("t5_reid",    32'(ev_id),    32'd2);
    ev_ready = 1'b1;
    repeat (4) tick();

    // 6: falling edge creates an event only in the both-edge build
    do_reset(4'b0000);
    drain();
    x = 4'b0001;
    repeat (6) tick();
    glog.delete();
    x = 4'b0000;
    repeat (6) tick();
`ifdef EDGE_BOTH_EN
    chk("t6_n",  32'(glog.size()), 32'd1);
    chk("t6_id", 32'(glog[0]),     32'd0);
`else
    chk("t6_n",  32'(glog.size()), 32'd0);
`endif

    // Randomized traffic with random backpressure and clears
    do_reset(4'b0000);
    drain();
    repeat (600) begin
      x        = x ^ (N'($urandom) & N'($urandom));
      ev_ready = ($urandom_range(0, 3) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    ovf_clr = 1'b0;

    // Reset while offering drops ev_valid at once and discards pending work
    x = 4'b0000;
    drain();
    ev_ready = 1'b0;
    x = 4'b1000;
    tick();
    tick();
    chk("mr_pre", 32'(ev_valid), 32'd1);
    reset = 1'b0;
    #2;
    chk("mr_drop", 32'(ev_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ev_ready = 1'b1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
